// File: rtl/regfile_writeback_if.sv
// Bundle of the issue, ALU-result, load-result and register-file write-port
// signals around the writeback controller.
interface regfile_writeback_if #(
   parameter int LD_DEPTH = 4,
   parameter int XLEN     = 32
);
   localparam int CW = $clog2(LD_DEPTH) + 1;

   logic            iss_valid;
   logic [4:0]      iss_rd;
   logic [4:0]      iss_rs1;
   logic [4:0]      iss_rs2;
   logic            iss_stall;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            ld_valid;
   logic            ld_ready;
   logic [4:0]      ld_rd;
   logic [XLEN-1:0] ld_data;
   logic            rf_we;
   logic [4:0]      rf_rd_addr;
   logic [XLEN-1:0] rf_wd;
   logic [CW-1:0]   ld_count;
   logic            wb_err;

   // Load handshake: a result transfers on a clock edge where ld_valid and
   // ld_ready are both high; ld_valid and its payload hold until then.
   // ALU results have no ready and are taken every cycle alu_valid is high.
   modport master (
      output iss_valid, iss_rd, iss_rs1, iss_rs2,
      output alu_valid, alu_rd, alu_data,
      output ld_valid, ld_rd, ld_data,
      input  iss_stall, ld_ready, rf_we, rf_rd_addr, rf_wd, ld_count, wb_err
   );

   modport slave (
      input  iss_valid, iss_rd, iss_rs1, iss_rs2,
      input  alu_valid, alu_rd, alu_data,
      input  ld_valid, ld_rd, ld_data,
      output iss_stall, ld_ready, rf_we, rf_rd_addr, rf_wd, ld_count, wb_err
   );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write-port controller: busy scoreboard, RAW/WAW issue stall,
// load-result FIFO and ALU-priority arbitration onto one registered write port.
module regfile_writeback #(
   parameter int LD_DEPTH = 4,
   parameter int XLEN     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_writeback_if.slave   bus
);
   localparam int AW = $clog2(LD_DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]     busy;
   logic [31:0]     busy_nxt;
   logic [4:0]      fifo_rd   [LD_DEPTH];
   logic [XLEN-1:0] fifo_data [LD_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            iss_accept;
   logic            sel_valid;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;
   logic            commit;

   assign full  = (count == CW'(LD_DEPTH));
   assign empty = (count == '0);

   assign bus.iss_stall = bus.iss_valid &
                          (busy[bus.iss_rs1] | busy[bus.iss_rs2] | busy[bus.iss_rd]);
   assign iss_accept    = bus.iss_valid & ~bus.iss_stall & (bus.iss_rd != 5'd0);

   // No pass-through: a full FIFO refuses a push even if it pops this cycle.
   assign bus.ld_ready = ~rst & ~full;
   assign push         = bus.ld_valid & bus.ld_ready;
   assign bus.ld_count = count;

   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = 5'd0;
      sel_data  = '0;
      pop       = 1'b0;
      if (bus.alu_valid) begin
         sel_valid = 1'b1;
         sel_rd    = bus.alu_rd;
         sel_data  = bus.alu_data;
      end else if (!empty) begin
         sel_valid = 1'b1;
         sel_rd    = fifo_rd[rd_ptr];
         sel_data  = fifo_data[rd_ptr];
         pop       = 1'b1;
      end
   end

   assign commit = sel_valid & (sel_rd != 5'd0);

   // Clear before set so an issue to the same register wins.
   always_comb begin
      busy_nxt = busy;
      if (commit)     busy_nxt[sel_rd]     = 1'b0;
      if (iss_accept) busy_nxt[bus.iss_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= bus.ld_rd;
         fifo_data[wr_ptr] <= bus.ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rf_we      <= 1'b0;
         bus.rf_rd_addr <= 5'd0;
         bus.rf_wd      <= '0;
         bus.wb_err     <= 1'b0;
      end else begin
         bus.rf_we <= commit;
         if (commit) begin
            bus.rf_rd_addr <= sel_rd;
            bus.rf_wd      <= sel_data;
            if (!busy[sel_rd]) bus.wb_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: scoreboard stalls, ALU/load arbitration,
// FIFO ordering, x0 handling, wb_err and mid-run reset.
module tb_regfile_writeback;
   localparam int LD_DEPTH = 4;
   localparam int XLEN     = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   regfile_writeback_if #(.LD_DEPTH(LD_DEPTH), .XLEN(XLEN)) bus ();

   regfile_writeback #(.LD_DEPTH(LD_DEPTH), .XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.iss_valid = 1'b0; bus.iss_rd = 5'd0; bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0;
      bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = '0;
      bus.ld_valid  = 1'b0; bus.ld_rd  = 5'd0; bus.ld_data  = '0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      bus.iss_valid = 1'b1; bus.iss_rd = rd; bus.iss_rs1 = rs1; bus.iss_rs2 = rs2;
   endtask

   task automatic alu(input logic [4:0] rd, input logic [XLEN-1:0] d);
      bus.alu_valid = 1'b1; bus.alu_rd = rd; bus.alu_data = d;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick(); tick();
      n_checks++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ld_ready got=%b exp=0", bus.ld_ready); end
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_rf_we got=%b exp=0", bus.rf_we); end
      n_checks++; if (bus.rf_rd_addr !== 5'd0) begin n_fail++; $display("FAIL rst_rf_rd_addr got=%0d exp=0", bus.rf_rd_addr); end
      n_checks++; if (bus.rf_wd !== 32'd0) begin n_fail++; $display("FAIL rst_rf_wd got=%h exp=0", bus.rf_wd); end
      n_checks++; if (bus.ld_count !== 3'd0) begin n_fail++; $display("FAIL rst_ld_count got=%0d exp=0", bus.ld_count); end
      n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL rst_wb_err got=%b exp=0", bus.wb_err); end
      rst = 1'b0;
      #1;
      n_checks++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ld_ready got=%b exp=1", bus.ld_ready); end
      tick();
   endtask

   task automatic test_raw();
      issue(5'd5, 5'd1, 5'd2);
      #1;
      n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL raw_first_issue_stall got=%b exp=0", bus.iss_stall); end
      tick();
      issue(5'd6, 5'd5, 5'd0);
      #1;
      n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++; $display("FAIL raw_dep_stall got=%b exp=1", bus.iss_stall); end
      alu(5'd5, 32'hDEADBEEF);
      tick();
      bus.alu_valid = 1'b0;
      #1;
      n_checks++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL raw_rf_we got=%b exp=1", bus.rf_we); end
      n_checks++; if (bus.rf_rd_addr !== 5'd5) begin n_fail++; $display("FAIL raw_rf_rd_addr got=%0d exp=5", bus.rf_rd_addr); end
      n_checks++; if (bus.rf_wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL raw_rf_wd got=%h exp=deadbeef", bus.rf_wd); end
      n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL raw_unstall got=%b exp=0", bus.iss_stall); end
      tick();
      bus.iss_valid = 1'b0;
      issue(5'd0, 5'd6, 5'd0);
      #1;
      n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++; $display("FAIL raw_rd6_busy got=%b exp=1", bus.iss_stall); end
      bus.iss_valid = 1'b0;
      alu(5'd6, 32'h0000_0066);
      tick();
      bus.alu_valid = 1'b0;
      n_checks++; if (bus.rf_rd_addr !== 5'd6 || bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL raw_rd6_commit got=%0d/%b exp=6/1", bus.rf_rd_addr, bus.rf_we); end
      n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL raw_wb_err got=%b exp=0", bus.wb_err); end
      tick();
   endtask

   task automatic test_x0();
      issue(5'd0, 5'd0, 5'd0);
      #1;
      n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL x0_issue_stall got=%b exp=0", bus.iss_stall); end
      tick();
      alu(5'd0, 32'h0000_1234);
      #1;
      n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL x0_issue2_stall got=%b exp=0", bus.iss_stall); end
      tick();
      idle();
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_rf_we got=%b exp=0", bus.rf_we); end
      n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL x0_wb_err got=%b exp=0", bus.wb_err); end
      tick();
      n_checks++; if (bus.rf_rd_addr !== 5'd6 || bus.rf_wd !== 32'h66) begin n_fail++; $display("FAIL x0_hold got=%0d/%h exp=6/66", bus.rf_rd_addr, bus.rf_wd); end
   endtask

   task automatic test_load_fifo();
      for (int i = 1; i <= 4; i++) begin
         issue(5'(i), 5'd0, 5'd0);
         tick();
      end
      bus.iss_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         alu(5'd0, 32'hFFFF_0000);
         bus.ld_valid = 1'b1; bus.ld_rd = 5'(i); bus.ld_data = 32'h100 + 32'(i);
         tick();
      end
      bus.ld_valid = 1'b0;
      #1;
      n_checks++; if (bus.ld_count !== 3'd4) begin n_fail++; $display("FAIL ld_full_count got=%0d exp=4", bus.ld_count); end
      n_checks++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL ld_full_ready got=%b exp=0", bus.ld_ready); end
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL ld_starved_rf_we got=%b exp=0", bus.rf_we); end
      bus.alu_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_addr !== 5'(i)) begin n_fail++; $display("FAIL ld_order_%0d got=%b/%0d exp=1/%0d", i, bus.rf_we, bus.rf_rd_addr, i); end
         n_checks++; if (bus.rf_wd !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL ld_data_%0d got=%h exp=%h", i, bus.rf_wd, 32'h100 + 32'(i)); end
         n_checks++; if (bus.ld_count !== 3'(4 - i)) begin n_fail++; $display("FAIL ld_count_%0d got=%0d exp=%0d", i, bus.ld_count, 4 - i); end
      end
      n_checks++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL ld_drained_ready got=%b exp=1", bus.ld_ready); end
      n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL ld_wb_err got=%b exp=0", bus.wb_err); end
      issue(5'd0, 5'd1, 5'd4);
      #1;
      n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL ld_busy_cleared got=%b exp=0", bus.iss_stall); end
      bus.iss_valid = 1'b0;
      tick();
      n_checks++; if (bus.rf_we !== 1'b0 || bus.rf_rd_addr !== 5'd4) begin n_fail++; $display("FAIL ld_idle got=%b/%0d exp=0/4", bus.rf_we, bus.rf_rd_addr); end
   endtask

   task automatic test_same_cycle();
      issue(5'd7, 5'd0, 5'd0); tick();
      issue(5'd8, 5'd0, 5'd0); tick();
      bus.iss_valid = 1'b0;
      alu(5'd0, 32'h0);
      bus.ld_valid = 1'b1; bus.ld_rd = 5'd8; bus.ld_data = 32'h800;
      tick();
      bus.ld_valid = 1'b0;
      alu(5'd7, 32'h700);
      tick();
      bus.alu_valid = 1'b0;
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_addr !== 5'd7 || bus.rf_wd !== 32'h700) begin n_fail++; $display("FAIL same_alu_first got=%b/%0d/%h exp=1/7/700", bus.rf_we, bus.rf_rd_addr, bus.rf_wd); end
      n_checks++; if (bus.ld_count !== 3'd1) begin n_fail++; $display("FAIL same_load_waits got=%0d exp=1", bus.ld_count); end
      issue(5'd0, 5'd7, 5'd0);
      #1;
      n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL same_busy7 got=%b exp=0", bus.iss_stall); end
      bus.iss_rs1 = 5'd8;
      #1;
      n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++; $display("FAIL same_busy8 got=%b exp=1", bus.iss_stall); end
      bus.iss_valid = 1'b0;
      tick();
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_addr !== 5'd8 || bus.rf_wd !== 32'h800) begin n_fail++; $display("FAIL same_load_second got=%b/%0d/%h exp=1/8/800", bus.rf_we, bus.rf_rd_addr, bus.rf_wd); end
      issue(5'd0, 5'd8, 5'd0);
      #1;
      n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL same_busy8_clear got=%b exp=0", bus.iss_stall); end
      bus.iss_valid = 1'b0;
      tick();
   endtask

   task automatic test_waw();
      issue(5'd9, 5'd0, 5'd0);
      tick();
      #1;
      n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall got=%b exp=1", bus.iss_stall); end
      tick(); tick();
      n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall_hold got=%b exp=1", bus.iss_stall); end
      alu(5'd9, 32'h900);
      tick();
      bus.alu_valid = 1'b0;
      #1;
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_addr !== 5'd9) begin n_fail++; $display("FAIL waw_commit got=%b/%0d exp=1/9", bus.rf_we, bus.rf_rd_addr); end
      n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL waw_release got=%b exp=0", bus.iss_stall); end
      tick();
      issue(5'd0, 5'd9, 5'd0);
      #1;
      n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++; $display("FAIL waw_second_accepted got=%b exp=1", bus.iss_stall); end
      bus.iss_valid = 1'b0;
      alu(5'd9, 32'h901);
      tick();
      bus.alu_valid = 1'b0;
      n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL waw_wb_err got=%b exp=0", bus.wb_err); end
      tick();
   endtask

   task automatic test_wb_err_reset();
      alu(5'd12, 32'hC00);
      tick();
      bus.alu_valid = 1'b0;
      n_checks++; if (bus.wb_err !== 1'b1) begin n_fail++; $display("FAIL err_set got=%b exp=1", bus.wb_err); end
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_addr !== 5'd12) begin n_fail++; $display("FAIL err_still_commits got=%b/%0d exp=1/12", bus.rf_we, bus.rf_rd_addr); end
      tick();
      n_checks++; if (bus.wb_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", bus.wb_err); end
      n_checks++; if (bus.rf_we !== 1'b0 || bus.rf_wd !== 32'hC00) begin n_fail++; $display("FAIL err_idle_hold got=%b/%h exp=0/c00", bus.rf_we, bus.rf_wd); end
      issue(5'd13, 5'd0, 5'd0);
      tick();
      bus.iss_valid = 1'b0;
      alu(5'd0, 32'h0);
      bus.ld_valid = 1'b1; bus.ld_rd = 5'd13; bus.ld_data = 32'hD00;
      tick(); tick();
      bus.ld_valid = 1'b0;
      n_checks++; if (bus.ld_count !== 3'd2) begin n_fail++; $display("FAIL err_fifo_fill got=%0d exp=2", bus.ld_count); end
      bus.alu_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ld_ready got=%b exp=0", bus.ld_ready); end
      tick();
      n_checks++; if (bus.ld_count !== 3'd0) begin n_fail++; $display("FAIL mid_rst_count got=%0d exp=0", bus.ld_count); end
      n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wb_err got=%b exp=0", bus.wb_err); end
      n_checks++; if (bus.rf_we !== 1'b0 || bus.rf_rd_addr !== 5'd0 || bus.rf_wd !== 32'd0) begin n_fail++; $display("FAIL mid_rst_rf got=%b/%0d/%h exp=0/0/0", bus.rf_we, bus.rf_rd_addr, bus.rf_wd); end
      rst = 1'b0;
      issue(5'd0, 5'd13, 5'd0);
      #1;
      n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", bus.iss_stall); end
      n_checks++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ld_ready got=%b exp=1", bus.ld_ready); end
      bus.iss_valid = 1'b0;
      tick();
      n_checks++; if (bus.rf_we !== 1'b0 || bus.ld_count !== 3'd0) begin n_fail++; $display("FAIL post_rst_discard got=%b/%0d exp=0/0", bus.rf_we, bus.ld_count); end
   endtask

   initial begin
      idle();
      test_reset();
      test_raw();
      test_x0();
      test_load_fifo();
      test_same_cycle();
      test_waw();
      test_wb_err_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
